// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Two-entry pipeline register with a registered upstream ready. A "main"
// register drives the downstream payload and a "skid" register catches the
// one beat that can arrive while the downstream stalls. Because s_ready
// comes straight from a flop, the upstream ready path is cut: s_ready does
// not depend combinationally on m_ready or s_valid.
//
// Also keeps a saturating count of back-pressured cycles, meaning cycles in
// which a valid beat is offered downstream and is not taken.
//
// Parameters
//   DW          payload width in bits
//   CNT_W       width of the stall-cycle counter
//   ZERO_BUBBLE 1: clear registers as they are vacated, 0: keep their contents
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous discard of every held beat
//   cnt_clr    synchronous clear of stall_cnt
//   s_valid    upstream beat valid
//   s_ready    stage can accept a beat (registered)
//   s_data     upstream payload
//   m_valid    downstream beat valid
//   m_ready    downstream accepts
//   m_data     downstream payload (the main register)
//   stall_cnt  saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DW          = 102,
    parameter int CNT_W       = 16,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     main_reg,  main_next;
    logic [DW-1:0]     skid_reg,  skid_next;
    logic              s_ready_reg;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;

    logic              accept;
    logic              emit;
    logic              m_valid_int;
    logic [DW-1:0]     main_vacated;
    logic [DW-1:0]     skid_vacated;

    // Occupancy is fully described by the state, so m_valid is a decode of
    // the state register and carries no input-to-output path.
    assign m_valid_int = (state_reg != ST_EMPTY);
    assign accept      = s_valid & s_ready_reg;
    assign emit        = m_valid_int & m_ready;

    // Value a register takes when its beat leaves: zero in bubble-clearing
    // mode, otherwise the old contents stay put.
    assign main_vacated = (ZERO_BUBBLE != 0) ? '0 : main_reg;
    assign skid_vacated = (ZERO_BUBBLE != 0) ? '0 : skid_reg;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;

        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_ONE;
                    main_next  = s_data;
                end
            end

            ST_ONE: begin
                if (accept && emit) begin
                    // Pass-through: the new beat replaces the departing one.
                    main_next = s_data;
                end else if (accept) begin
                    // Downstream stalled: park the new beat in the skid slot.
                    state_next = ST_FULL;
                    skid_next  = s_data;
                end else if (emit) begin
                    state_next = ST_EMPTY;
                    main_next  = main_vacated;
                end
            end

            ST_FULL: begin
                // s_ready is low here, so only an emit can change anything.
                if (emit) begin
                    state_next = ST_ONE;
                    main_next  = skid_reg;
                    skid_next  = skid_vacated;
                end
            end

            default: begin
                state_next = ST_EMPTY;
                main_next  = main_vacated;
                skid_next  = skid_vacated;
            end
        endcase

        // Flush wins over any same-cycle accept or emit. In retain mode the
        // registers keep their pre-flush contents rather than whatever the
        // accept/emit path above would have loaded.
        if (flush) begin
            state_next = ST_EMPTY;
            main_next  = main_vacated;
            skid_next  = skid_vacated;
        end
    end

    // -------------------------------------------------------------------------
    // Stall counter: clear has priority, then a saturating increment.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (m_valid_int && !m_ready && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_EMPTY;
            main_reg    <= '0;
            skid_reg    <= '0;
            s_ready_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            main_reg    <= main_next;
            skid_reg    <= skid_next;
            // Ready is computed one cycle early from the next state, so it
            // is a plain flop output. It stays low while reset is held and
            // rises at the first edge after release.
            s_ready_reg <= (state_next != ST_FULL);
            cnt_reg     <= cnt_next;
        end
    end

    assign s_ready   = s_ready_reg;
    assign m_valid   = m_valid_int;
    assign m_data    = main_reg;
    assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Directed table of single-cycle vectors (inputs plus hand-computed outputs
// after the edge), followed by hand-written multi-cycle sequences for counter
// saturation and mid-transfer reset, and a randomized scoreboard run.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int DW    = 102;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             cnt_clr;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_stage #(
        .DW          (DW),
        .CNT_W       (CNT_W),
        .ZERO_BUBBLE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             flush;
        logic             cnt_clr;
        logic             sv;
        logic [DW-1:0]    sd;
        logic             mr;
        logic             exp_sr;
        logic             exp_mv;
        logic [DW-1:0]    exp_md;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [DW-1:0] WIDE = {6'h2a, 32'hdeadbeef, 32'h12345678, 32'hcafef00d};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic cc, input logic sv, input logic [DW-1:0] sd,
                       input logic mr, input logic esr, input logic emv,
                       input logic [DW-1:0] emd, input logic [CNT_W-1:0] ecnt);
        vec_t v;
        v.flush = fl; v.cnt_clr = cc; v.sv = sv; v.sd = sd; v.mr = mr;
        v.exp_sr = esr; v.exp_mv = emv; v.exp_md = emd; v.exp_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic cc, input logic sv,
                         input logic [DW-1:0] sd, input logic mr);
        flush = fl; cnt_clr = cc; s_valid = sv; s_data = sd; m_ready = mr;
    endtask

    // Model storage for the random run.
    logic [DW-1:0] q[$];

    initial begin
        logic [127:0]  rnd;
        logic          r_sv, r_mr, r_fl;
        logic          acc, emt;
        int            n_acc, n_emit, n_flush;

        rst = 1'b1;
        drive(0, 0, 0, '0, 0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("reset_s_ready", s_ready, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        #1;
        chk("release_s_ready_low", s_ready, 0);
        @(posedge clk); #1;
        chk("first_edge_s_ready", s_ready, 1);
        chk("first_edge_m_valid", m_valid, 0);
        $display("reset: s_ready=%0b m_valid=%0b", s_ready, m_valid);

        // ---------------- directed table ----------------
        // Streaming 1..8 with m_ready high: one beat per cycle, 1-cycle latency.
        for (int i = 1; i <= 8; i++)
            add(0, 0, 1, DW'(i), 1, 1, 1, DW'(i), 0);
        add(0, 0, 0, '0, 1, 1, 0, '0, 0);                 // drain to empty, main zeroed
        // Back-pressure: A then B stall, C refused while full.
        add(0, 0, 1, DW'('hA), 0, 1, 1, DW'('hA), 0);
        add(0, 0, 1, DW'('hB), 0, 0, 1, DW'('hA), 1);     // full
        add(0, 0, 1, DW'('hC), 0, 0, 1, DW'('hA), 2);     // not accepted
        add(0, 0, 0, '0, 0, 0, 1, DW'('hA), 3);
        add(0, 0, 0, '0, 1, 1, 1, DW'('hB), 3);           // A out, B promoted
        add(0, 0, 0, '0, 1, 1, 0, '0, 3);                 // B out
        add(0, 1, 0, '0, 0, 1, 0, '0, 0);                 // counter clear
        // Flush from full with m_ready high and a beat offered.
        add(0, 0, 1, DW'('hA), 0, 1, 1, DW'('hA), 0);
        add(0, 0, 1, DW'('hB), 0, 0, 1, DW'('hA), 1);
        add(1, 0, 1, DW'('h77), 1, 1, 0, '0, 1);
        add(0, 0, 0, '0, 1, 1, 0, '0, 1);                 // nothing reappears
        add(1, 0, 1, DW'('h55), 1, 1, 0, '0, 1);          // accept during flush dropped
        add(0, 0, 1, DW'('h66), 1, 1, 1, DW'('h66), 1);
        add(0, 0, 0, '0, 1, 1, 0, '0, 1);
        // Idle data and m_ready toggles while empty have no effect.
        add(0, 0, 0, DW'('hFF), 0, 1, 0, '0, 1);
        add(0, 0, 0, DW'('hEE), 1, 1, 0, '0, 1);
        // Full-width payload.
        add(0, 0, 1, WIDE, 0, 1, 1, WIDE, 1);
        add(0, 0, 0, '0, 0, 1, 1, WIDE, 2);
        add(0, 0, 0, '0, 1, 1, 0, '0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].cnt_clr, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_sr);
            chk($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].exp_mv);
            chk($sformatf("vec%0d_m_data", i), m_data, vecs[i].exp_md);
            chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].exp_cnt);
            $display("vec %0d: fl=%0b clr=%0b sv=%0b mr=%0b -> sr=%0b mv=%0b md=%h cnt=%0d",
                     i, vecs[i].flush, vecs[i].cnt_clr, vecs[i].sv, vecs[i].mr,
                     s_ready, m_valid, m_data, stall_cnt);
        end

        // ---------------- counter saturation ----------------
        drive(0, 1, 1, DW'(9), 0);
        @(posedge clk); #1;
        chk("sat_start_cnt", stall_cnt, 0);
        drive(0, 0, 0, '0, 0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 14) chk("sat_cnt_14", stall_cnt, 14);
            if (i == 15) chk("sat_cnt_15", stall_cnt, 15);
        end
        chk("sat_cnt_20", stall_cnt, 15);
        chk("sat_m_data_held", m_data, 9);
        $display("saturate: stall_cnt=%0d after 20 stalled cycles", stall_cnt);
        drive(0, 1, 0, '0, 0);
        @(posedge clk); #1;
        chk("sat_clr_priority", stall_cnt, 0);
        drive(0, 0, 0, '0, 0);
        @(posedge clk); #1;
        chk("sat_after_clr", stall_cnt, 1);
        drive(0, 0, 0, '0, 1);
        @(posedge clk); #1;
        chk("sat_drain_m_valid", m_valid, 0);
        chk("sat_drain_cnt", stall_cnt, 1);
        $display("saturate: cleared and drained, stall_cnt=%0d", stall_cnt);

        // ---------------- reset while full ----------------
        drive(0, 0, 1, DW'('h11), 0);
        @(posedge clk); #1;
        drive(0, 0, 1, DW'('h22), 0);
        @(posedge clk); #1;
        chk("rst_pre_full_s_ready", s_ready, 0);
        drive(0, 0, 0, '0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_m_valid", m_valid, 0);
        chk("rst_async_m_data", m_data, 0);
        chk("rst_async_s_ready", s_ready, 0);
        chk("rst_async_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_release_s_ready", s_ready, 0);
        @(posedge clk); #1;
        chk("rst_edge_s_ready", s_ready, 1);
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_no_stale_%0d", i), m_valid, 0);
        end
        $display("reset mid-op: s_ready=%0b m_valid=%0b m_data=%h", s_ready, m_valid, m_data);

        // ---------------- random scoreboard ----------------
        q.delete();
        n_acc = 0; n_emit = 0; n_flush = 0;
        for (int c = 0; c < 10000; c++) begin
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            r_sv = 1'($urandom_range(0, 1));
            r_mr = ($urandom_range(0, 3) != 0);
            r_fl = ($urandom_range(0, 49) == 0);
            drive(r_fl, 0, r_sv, rnd[DW-1:0], r_mr);
            @(negedge clk);
            chk("rnd_m_valid", m_valid, (q.size() != 0));
            chk("rnd_s_ready", s_ready, (q.size() < 2));
            if (q.size() != 0) chk("rnd_m_data", m_data, q[0]);
            else               chk("rnd_m_data_bubble", m_data, 0);
            acc = r_sv && (q.size() < 2);
            emt = r_mr && (q.size() != 0);
            @(posedge clk);
            if (r_fl) begin
                q.delete();
                n_flush++;
            end else begin
                if (emt) begin
                    void'(q.pop_front());
                    n_emit++;
                end
                if (acc) begin
                    q.push_back(rnd[DW-1:0]);
                    n_acc++;
                end
            end
            #1;
        end
        $display("random: %0d accepted, %0d emitted, %0d flushes", n_acc, n_emit, n_flush);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DW, default 102: payload width in bits; one bit-packed bundle of pipeline-register fields (wdata 32 + wr_en 1 + wr_addr 5 + pc 32 + inst 32).
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 Parameter ZERO_BUBBLE, default 1: 1 means the output payload register is forced to all-zero whenever the stage holds no valid beat; 0 means it holds its last value.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port flush, input, 1: synchronous discard of all held beats.
REQ-007 Port cnt_clr, input, 1: synchronous clear of stall_cnt.
REQ-008 Port s_valid, input, 1: upstream beat valid.
REQ-009 Port s_ready, output, 1: stage can accept a beat.
REQ-010 Port s_data, input, DW: upstream payload.
REQ-011 Port m_valid, output, 1: downstream beat valid.
REQ-012 Port m_ready, input, 1: downstream accepts.
REQ-013 Port m_data, output, DW: downstream payload.
REQ-014 Port stall_cnt, output, CNT_W: saturating count of back-pressured cycles.

Function
REQ-015 Block SHALL hold up to two beats: a main register (drives m_data) and a skid register; state is EMPTY (0 beats), ONE (main valid) or FULL (main and skid valid).
REQ-016 Accept SHALL occur when s_valid and s_ready are both 1 on a rising edge; emit SHALL occur when m_valid and m_ready are both 1.
REQ-017 m_valid SHALL be 1 exactly when state is ONE or FULL; m_data SHALL equal the main register.
REQ-018 s_ready SHALL be a register output, with no combinational path from m_ready or s_valid; it is 1 exactly when the current state is not FULL.
REQ-019 EMPTY: accept -> ONE, main <= s_data; latency from accept to m_valid is 1 cycle.
REQ-020 ONE: accept and emit -> ONE, main <= s_data; accept only -> FULL, skid <= s_data; emit only -> EMPTY; neither -> ONE, main unchanged.
REQ-021 FULL: emit -> ONE, main <= skid; no emit -> FULL, main and skid unchanged; no accept is possible in FULL.
REQ-022 Beats SHALL leave in acceptance order, each exactly once, never dropped except by flush.
REQ-023 With m_ready held at 1, the stage SHALL sustain one beat per cycle with no bubbles.
REQ-024 flush SHALL force the next state to EMPTY, overriding any same-cycle accept or emit; a beat accepted in the flush cycle is discarded; s_ready is 1 in the cycle after flush.
REQ-025 When ZERO_BUBBLE=1, the main register SHALL be all-zero whenever the state is EMPTY, including after emit-to-empty and after flush; the skid register SHALL be zeroed when it is vacated.
REQ-026 When ZERO_BUBBLE=0, vacated registers SHALL retain their contents.
REQ-027 stall_cnt SHALL increment by 1 each cycle in which m_valid=1 and m_ready=0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-028 cnt_clr SHALL set stall_cnt to 0 on the next edge, taking priority over a same-cycle increment; flush SHALL NOT affect stall_cnt.
REQ-029 Behaviour on s_data while s_valid=0 and on m_ready while m_valid=0 SHALL have no effect on state.

Reset
REQ-030 While rst=1, the following SHALL be forced asynchronously: state EMPTY, main=0, skid=0, m_valid=0, s_ready=0, stall_cnt=0.
REQ-031 s_ready SHALL become 1 at the first rising clk edge after rst deasserts.
REQ-032 rst asserted mid-transfer SHALL discard all held beats, with no partial beat emitted afterwards.

Verification
REQ-033 Streaming: after reset, s_valid=1 with data 1..8 on consecutive cycles and m_ready=1 -> m_data 1..8 on consecutive cycles, starting 1 cycle after the first accept; stall_cnt=0.
REQ-034 Back-pressure: send A and B, with m_ready=0 from the cycle A appears -> state FULL, s_ready=0, m_data=A held; stall_cnt counts 1 per stalled cycle. Then m_ready=1 -> A then B emitted, s_ready=1 again one cycle after the first emit.
REQ-035 Flush: with FULL (A,B), assert flush together with m_ready=1 -> next cycle m_valid=0, m_data=0 (ZERO_BUBBLE=1); neither B nor any beat offered in the flush cycle ever appears.
REQ-036 Saturation: CNT_W=4, hold m_valid=1 and m_ready=0 for 20 cycles -> stall_cnt=15; then cnt_clr=1 in a stalled cycle -> stall_cnt=0 next cycle.
REQ-037 Random: random s_valid/m_ready/flush over 10k cycles, DW=102 -> scoreboard shows in-order, lossless, duplicate-free delivery outside flushes; s_ready never 1 in FULL.
REQ-038 Reset mid-operation: assert rst for 1 cycle while FULL -> all outputs 0 immediately; s_ready=1 one edge after release; no stale beat is emitted.
